// File: rtl/rx_pkt_drop_fifo.sv
// rx_pkt_drop_fifo: store-and-forward packet FIFO for the C2H receive path.
// Each packet is written speculatively and becomes visible to the reader only
// once its tlast beat commits it. Dropped or overflowing packets are rolled back.
module rx_pkt_drop_fifo #(
    parameter int DEPTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             axis_aclk,
    input  logic             axis_areset,
    input  logic             s_axis_tvalid,
    input  logic [511:0]     s_axis_tdata,
    input  logic [63:0]      s_axis_tkeep,
    input  logic             s_axis_tlast,
    input  logic [47:0]      s_axis_tuser,
    input  logic             s_axis_tdrop,
    output logic             s_axis_tready,
    output logic             m_axis_tvalid,
    output logic [511:0]     m_axis_tdata,
    output logic [63:0]      m_axis_tkeep,
    output logic             m_axis_tlast,
    output logic [47:0]      m_axis_tuser,
    input  logic             m_axis_tready,
    output logic [CNT_W-1:0] pkt_pass_cnt,
    output logic [CNT_W-1:0] pkt_drop_cnt,
    output logic [CNT_W-1:0] pkt_ovfl_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = 1 + 48 + 64 + 512;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

    typedef enum logic {
        IDLE,
        PKT
    } wr_state_t;

    wr_state_t state, state_nxt;

    logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr;
    logic [PW-1:0] used, free;
    logic          ovfl, ovfl_nxt, ovfl_now;
    logic          beat_acc, free_zero;
    logic          wr_en, do_commit, do_rollback;
    logic          inc_pass, inc_drop, inc_ovfl;

    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] ram_q;
    logic          s1_valid;
    logic          out_load, rd_en;

    // The input side never stalls: ready simply follows reset.
    assign s_axis_tready = ~axis_areset;
    assign beat_acc      = s_axis_tvalid && s_axis_tready;

    // Occupancy is measured against the reader's registered pointer, so space
    // released by a read only becomes usable on the following cycle.
    assign used      = wr_ptr - rd_ptr;
    assign free      = DEPTH_P - used;
    assign free_zero = (free == '0);

    // Write FSM state register.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) state <= IDLE;
        else             state <= state_nxt;
    end

    // Next state: any accepted beat ends up inside a packet unless it closes one.
    always_comb begin
        state_nxt = state;
        if (beat_acc) state_nxt = s_axis_tlast ? IDLE : PKT;
    end

    // Per-beat decision: write, commit, roll back, and which counter to bump.
    always_comb begin
        ovfl_now    = 1'b0;
        ovfl_nxt    = ovfl;
        wr_en       = 1'b0;
        do_commit   = 1'b0;
        do_rollback = 1'b0;
        inc_pass    = 1'b0;
        inc_drop    = 1'b0;
        inc_ovfl    = 1'b0;
        if (beat_acc) begin
            ovfl_now = ((state == PKT) && ovfl) || free_zero;
            if (s_axis_tlast) begin
                ovfl_nxt = 1'b0;
                if (ovfl_now) begin
                    do_rollback = 1'b1;
                    inc_ovfl    = 1'b1;
                end else if (s_axis_tdrop) begin
                    do_rollback = 1'b1;
                    inc_drop    = 1'b1;
                end else begin
                    wr_en     = 1'b1;
                    do_commit = 1'b1;
                    inc_pass  = 1'b1;
                end
            end else if (ovfl_now) begin
                ovfl_nxt = 1'b1;
            end else begin
                wr_en = 1'b1;
            end
        end
    end

    // Speculative write pointer, commit pointer and sticky overflow flag.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            ovfl       <= 1'b0;
        end else begin
            if (do_rollback)  wr_ptr <= commit_ptr;
            else if (wr_en)   wr_ptr <= wr_ptr + PW'(1);
            if (do_commit)    commit_ptr <= wr_ptr + PW'(1);
            ovfl <= ovfl_nxt;
        end
    end

    // Packet storage write port.
    always_ff @(posedge axis_aclk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tuser, s_axis_tkeep, s_axis_tdata};
    end

    // Reads only walk committed data; the two output stages prefetch ahead.
    assign out_load = s1_valid && (!m_axis_tvalid || m_axis_tready);
    assign rd_en    = (rd_ptr != commit_ptr) && (!s1_valid || out_load);

    // Packet storage registered read port.
    always_ff @(posedge axis_aclk) begin
        if (rd_en) ram_q <= mem[rd_ptr[AW-1:0]];
    end

    // Read pointer and validity of the RAM output register.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            rd_ptr   <= '0;
            s1_valid <= 1'b0;
        end else begin
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
            if (rd_en)         s1_valid <= 1'b1;
            else if (out_load) s1_valid <= 1'b0;
        end
    end

    // Output register: holds its beat steady while the consumer stalls.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (out_load) begin
            m_axis_tvalid <= 1'b1;
            {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata} <= ram_q;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Saturating packet statistics.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            pkt_pass_cnt <= '0;
            pkt_drop_cnt <= '0;
            pkt_ovfl_cnt <= '0;
        end else begin
            if (inc_pass && (pkt_pass_cnt != '1)) pkt_pass_cnt <= pkt_pass_cnt + CNT_W'(1);
            if (inc_drop && (pkt_drop_cnt != '1)) pkt_drop_cnt <= pkt_drop_cnt + CNT_W'(1);
            if (inc_ovfl && (pkt_ovfl_cnt != '1)) pkt_ovfl_cnt <= pkt_ovfl_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rx_pkt_drop_fifo.sv
// tb_rx_pkt_drop_fifo: scoreboard bench for the packet drop FIFO.
// Passed packets are queued when their tlast is driven; a monitor pops them as
// the DUT emits beats.
module tb_rx_pkt_drop_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic         last;
        logic [47:0]  user;
        logic [63:0]  keep;
        logic [511:0] data;
    } beat_t;

    logic             axis_aclk;
    logic             axis_areset;
    logic             s_axis_tvalid;
    logic [511:0]     s_axis_tdata;
    logic [63:0]      s_axis_tkeep;
    logic             s_axis_tlast;
    logic [47:0]      s_axis_tuser;
    logic             s_axis_tdrop;
    logic             s_axis_tready;
    logic             m_axis_tvalid;
    logic [511:0]     m_axis_tdata;
    logic [63:0]      m_axis_tkeep;
    logic             m_axis_tlast;
    logic [47:0]      m_axis_tuser;
    logic             m_axis_tready;
    logic [CNT_W-1:0] pkt_pass_cnt;
    logic [CNT_W-1:0] pkt_drop_cnt;
    logic [CNT_W-1:0] pkt_ovfl_cnt;

    beat_t expQ[$];
    int    compared = 0;
    int    mismatched = 0;
    int    cycle = 0;
    int    lastTlastCycle = 0;
    int    committedBeats = 0;
    int    partialBeats = 0;
    int    outCount = 0;
    int    readyMode = 1;
    bit    watchReady = 0;
    bit    readyLow = 0;
    bit    prevStall = 0;
    beat_t prevBeat;
    beat_t monBeat;
    beat_t expBeat;

    rx_pkt_drop_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .axis_aclk     (axis_aclk),
        .axis_areset   (axis_areset),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tdrop  (s_axis_tdrop),
        .s_axis_tready (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tready (m_axis_tready),
        .pkt_pass_cnt  (pkt_pass_cnt),
        .pkt_drop_cnt  (pkt_drop_cnt),
        .pkt_ovfl_cnt  (pkt_ovfl_cnt)
    );

    // Free-running clock.
    initial begin
        axis_aclk = 1'b0;
        forever #5 axis_aclk = ~axis_aclk;
    end

    // Cycle index used for latency measurement.
    always @(posedge axis_aclk) cycle = cycle + 1;

    // Downstream ready: held low, held high, or coin-flip per cycle.
    always @(posedge axis_aclk) begin
        #1;
        case (readyMode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    always @(negedge axis_aclk) begin
        monBeat = {m_axis_tlast, m_axis_tuser, m_axis_tkeep, m_axis_tdata};
        if (axis_areset) begin
            prevStall = 1'b0;
        end else begin
            if (watchReady && !s_axis_tready) readyLow = 1'b1;
            if (prevStall) begin
                compared++;
                if (!m_axis_tvalid || monBeat !== prevBeat) begin
                    mismatched++;
                    $display("[TB] FAIL stall_stable: got valid=%0b data=%h, expected valid=1 data=%h",
                             m_axis_tvalid, monBeat.data[63:0], prevBeat.data[63:0]);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                outCount++;
                compared++;
                if (expQ.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_beat: got data=%h last=%0b, expected no beat",
                             monBeat.data[63:0], monBeat.last);
                end else begin
                    expBeat = expQ.pop_front();
                    if (monBeat !== expBeat) begin
                        mismatched++;
                        $display("[TB] FAIL out_beat: got last=%0b user=%h keep=%h data=%h, expected last=%0b user=%h keep=%h data=%h",
                                 monBeat.last, monBeat.user, monBeat.keep, monBeat.data[63:0],
                                 expBeat.last, expBeat.user, expBeat.keep, expBeat.data[63:0]);
                    end
                end
            end
            prevStall = m_axis_tvalid && !m_axis_tready;
            prevBeat  = monBeat;
        end
    end

    function automatic logic [511:0] randData();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    // Drives one packet; passed packets go to the scoreboard on their tlast beat.
    // With gate set, a beat is held back until the buffer provably has room.
    task automatic applyStimulus(input int nBeats, input bit drop, input bit expectPass, input bit gate);
        beat_t pkt[$];
        beat_t b;
        int    waitCnt;
        for (int i = 0; i < nBeats; i++) begin
            b.data = randData();
            b.user = {16'($urandom()), 32'($urandom())};
            b.last = (i == nBeats - 1);
            b.keep = b.last ? {32'($urandom()), 32'($urandom())} : '1;
            if (gate) begin
                waitCnt = 0;
                while ((committedBeats + partialBeats - outCount >= DEPTH) && (waitCnt < 2000)) begin
                    s_axis_tvalid = 1'b0;
                    @(posedge axis_aclk); #1;
                    waitCnt++;
                end
                if (waitCnt >= 2000) checkOutput("gate_timeout", 64'(waitCnt), 64'(0));
            end
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = b.data;
            s_axis_tkeep  = b.keep;
            s_axis_tuser  = b.user;
            s_axis_tlast  = b.last;
            s_axis_tdrop  = b.last ? drop : 1'($urandom_range(0, 1));
            pkt.push_back(b);
            if (b.last) begin
                lastTlastCycle = cycle;
                if (expectPass) begin
                    foreach (pkt[k]) expQ.push_back(pkt[k]);
                    committedBeats += nBeats;
                end
                partialBeats = 0;
            end else begin
                partialBeats++;
            end
            @(posedge axis_aclk); #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdrop  = 1'b0;
    endtask

    task automatic clearModel();
        expQ.delete();
        committedBeats = 0;
        partialBeats   = 0;
        outCount       = 0;
    endtask

    task automatic doReset();
        axis_areset   = 1'b1;
        s_axis_tvalid = 1'b0;
        @(posedge axis_aclk); #1;
        clearModel();
        checkOutput("reset_s_tready", 64'(s_axis_tready), 64'(0));
        checkOutput("reset_m_tvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("reset_counters", 64'(pkt_pass_cnt | pkt_drop_cnt | pkt_ovfl_cnt), 64'(0));
        axis_areset = 1'b0;
        @(posedge axis_aclk); #1;
        checkOutput("post_reset_s_tready", 64'(s_axis_tready), 64'(1));
    endtask

    task automatic waitDrain(input string name);
        int n = 0;
        while (((expQ.size() != 0) || m_axis_tvalid) && (n < 3000)) begin
            @(posedge axis_aclk); #1;
            n++;
        end
        repeat (8) @(posedge axis_aclk);
        #1;
        checkOutput(name, 64'(expQ.size()), 64'(0));
    endtask

    task automatic checkCounters(input string name, input int pass, input int drop, input int ovfl);
        checkOutput({name, "_pass"}, 64'(pkt_pass_cnt), 64'(pass));
        checkOutput({name, "_drop"}, 64'(pkt_drop_cnt), 64'(drop));
        checkOutput({name, "_ovfl"}, 64'(pkt_ovfl_cnt), 64'(ovfl));
    endtask

    // Hard stop in case something hangs despite the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int expPass;
        int expDrop;
        int latency;
        bit drop;

        axis_areset   = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = '0;
        s_axis_tdrop  = 1'b0;
        m_axis_tready = 1'b1;
        @(posedge axis_aclk); #1;
        doReset();

        $display("[TB] single pass");
        applyStimulus(3, 1'b0, 1'b1, 1'b0);
        checkCounters("single_T1", 1, 0, 0);
        n = 0;
        while (!m_axis_tvalid && n < 20) begin
            @(negedge axis_aclk);
            n++;
        end
        latency = cycle - lastTlastCycle;
        checkOutput("first_beat_latency", 64'(latency), 64'(3));
        @(posedge axis_aclk); #1;
        waitDrain("single_drain");
        checkCounters("single", 1, 0, 0);

        doReset();
        $display("[TB] verdict drop");
        applyStimulus(4, 1'b1, 1'b0, 1'b0);
        applyStimulus(2, 1'b0, 1'b1, 1'b0);
        waitDrain("drop_drain");
        checkCounters("drop", 1, 1, 0);

        readyMode = 0;
        doReset();
        $display("[TB] overflow");
        applyStimulus(10, 1'b0, 1'b1, 1'b0);
        applyStimulus(10, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge axis_aclk);
        #1;
        checkCounters("ovfl", 1, 0, 1);
        readyMode = 1;
        waitDrain("ovfl_drain");
        checkOutput("ovfl_out_beats", 64'(outCount), 64'(10));

        doReset();
        $display("[TB] oversize");
        applyStimulus(20, 1'b0, 1'b0, 1'b0);
        repeat (5) @(posedge axis_aclk);
        #1;
        checkCounters("oversize", 0, 0, 1);
        readyMode = 0;
        applyStimulus(DEPTH, 1'b0, 1'b1, 1'b0);
        repeat (3) @(posedge axis_aclk);
        #1;
        checkCounters("full_fit", 1, 0, 1);
        readyMode = 1;
        waitDrain("full_fit_drain");
        checkOutput("full_fit_beats", 64'(outCount), 64'(DEPTH));

        doReset();
        $display("[TB] random stress");
        expPass    = 0;
        expDrop    = 0;
        readyLow   = 1'b0;
        watchReady = 1'b1;
        readyMode  = 2;
        for (int p = 0; p < 100; p++) begin
            n    = $urandom_range(1, 8);
            drop = ($urandom_range(0, 3) == 0);
            if (drop) expDrop++;
            else      expPass++;
            applyStimulus(n, drop, !drop, 1'b1);
        end
        watchReady = 1'b0;
        readyMode  = 1;
        waitDrain("stress_drain");
        checkCounters("stress", expPass, expDrop, 0);
        checkOutput("stress_sum", 64'(pkt_pass_cnt + pkt_drop_cnt + pkt_ovfl_cnt), 64'(100));
        checkOutput("stress_tready_low", 64'(readyLow), 64'(0));

        doReset();
        $display("[TB] reset mid-packet");
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = randData();
        s_axis_tkeep  = '1;
        s_axis_tuser  = 48'($urandom());
        s_axis_tlast  = 1'b0;
        s_axis_tdrop  = 1'b0;
        @(posedge axis_aclk); #1;
        s_axis_tdata  = randData();
        axis_areset   = 1'b1;
        @(posedge axis_aclk); #1;
        axis_areset   = 1'b0;
        s_axis_tvalid = 1'b0;
        clearModel();
        @(posedge axis_aclk); #1;
        applyStimulus(1, 1'b0, 1'b1, 1'b0);
        waitDrain("midrst_drain");
        checkOutput("midrst_beats", 64'(outCount), 64'(1));
        checkCounters("midrst", 1, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
